// File: rtl/arb_mux.sv
// ============================================================================
// Module   : arb_mux
// Purpose  : N-channel arbitrated multiplexer with a registered output stage.
//            One valid channel is granted per cycle (round-robin or fixed
//            priority). The selected word is held in the output register until
//            the consumer accepts it, together with the index of its source.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-high reset
//            in_valid   - per-channel request (bit i = channel i)
//            in_data    - channel i data at [i*WIDTH +: WIDTH]
//            in_ready   - one-hot (or zero) grant back to the channels
//            out_valid  - output register holds an unconsumed word
//            out_data   - registered selected word
//            out_sel    - index of the channel that supplied out_data
//            out_ready  - consumer accepts when out_valid & out_ready
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int RR    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    // After reset the pointer sits on the last channel so that the search
    // begins at channel 0.
    localparam logic [SELW-1:0] C_LAST_RST = SELW'(NCH - 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_last;

    logic             w_load;
    logic [SELW-1:0]  w_start;
    logic             w_found;
    logic [SELW-1:0]  w_winner;
    logic             w_xfer;

    // The output register can take a new word when empty or being drained.
    assign w_load = ~r_out_valid | out_ready;

    // First channel examined by the search.
    generate
        if (RR != 0) begin : g_rr_start
            assign w_start = (r_last == C_LAST_RST) ? '0 : (r_last + SELW'(1));
        end else begin : g_fixed_start
            assign w_start = '0;
        end
    endgenerate

    // Circular search from w_start; the first valid channel wins. Only the
    // request vector and pointer feed this, never the data.
    always_comb begin
        int              w_pos;
        logic [SELW-1:0] w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_pos    = 0;
        w_idx    = '0;
        for (int k = 0; k < NCH; k++) begin
            w_pos = int'(w_start) + k;
            if (w_pos >= NCH) begin
                w_pos = w_pos - NCH;
            end
            w_idx = SELW'(w_pos);
            if (!w_found && in_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // No grant while reset is high so no handshake completes on that edge.
    assign w_xfer = w_load & w_found & ~reset;

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_last      <= C_LAST_RST;
        end else if (w_xfer) begin
            // Covers simultaneous accept + new word: overwrite, no bubble.
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[int'(w_winner)*WIDTH +: WIDTH];
            r_out_sel   <= w_winner;
            if (RR != 0) begin
                r_last <= w_winner;
            end
        end else if (out_ready) begin
            // Drained with nothing new: data and index are left as they were.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire
